// File: rtl/dct8_in_framer.sv
// rtl/dct8_in_framer.sv - 8-sample serial-to-parallel framer feeding the 8-point DCT
// A collect buffer fills while the output register presents the previous frame.
module dct8_in_framer #(
   parameter int W          = 18,
   parameter int N          = 8,
   parameter bit CHECK_LAST = 1'b1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           s_valid,
   output logic           s_ready,
   input  logic [W-1:0]   s_data,
   input  logic           s_last,
   output logic           m_valid,
   input  logic           m_ready,
   output logic [N*W-1:0] m_data,
   output logic           err_frame,
   output logic [15:0]    frame_cnt
);

   logic [2:0]     idx_q, idx_d;
   logic [W-1:0]   word_q [N];
   logic [W-1:0]   word_d [N];
   logic           coll_full_q, coll_full_d;
   logic           m_valid_q, m_valid_d;
   logic [N*W-1:0] m_data_q, m_data_d;
   logic           err_q, err_d;
   logic [15:0]    frame_cnt_q, frame_cnt_d;
   logic           s_fire, m_fire;

   assign s_ready   = !coll_full_q;
   assign s_fire    = s_valid && !coll_full_q;
   assign m_fire    = m_valid_q && m_ready;
   assign m_valid   = m_valid_q;
   assign m_data    = m_data_q;
   assign err_frame = err_q;
   assign frame_cnt = frame_cnt_q;

   always_comb begin
      idx_d       = idx_q;
      word_d      = word_q;
      coll_full_d = coll_full_q;
      m_valid_d   = m_valid_q;
      m_data_d    = m_data_q;
      err_d       = 1'b0;
      frame_cnt_d = frame_cnt_q;

      // s_fire and coll_full_q are exclusive, so the two halves never fight over m_data_d.
      if (m_fire) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
         if (coll_full_q) begin
            for (int k = 0; k < N; k++) m_data_d[k*W +: W] = word_q[k];
            coll_full_d = 1'b0;
         end else begin
            m_valid_d = 1'b0;
         end
      end

      if (s_fire) begin
         if (idx_q != 3'd7) begin
            if (CHECK_LAST && s_last) begin
               idx_d = 3'd0;
               err_d = 1'b1;
            end else begin
               word_d[idx_q] = s_data;
               idx_d         = idx_q + 3'd1;
            end
         end else begin
            idx_d = 3'd0;
            err_d = CHECK_LAST && !s_last;
            if (!m_valid_q || m_fire) begin
               for (int k = 0; k < N-1; k++) m_data_d[k*W +: W] = word_q[k];
               m_data_d[(N-1)*W +: W] = s_data;
               m_valid_d = 1'b1;
            end else begin
               word_d[N-1] = s_data;
               coll_full_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q       <= 3'd0;
         for (int k = 0; k < N; k++) word_q[k] <= '0;
         coll_full_q <= 1'b0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         err_q       <= 1'b0;
         frame_cnt_q <= 16'd0;
      end else begin
         idx_q       <= idx_d;
         word_q      <= word_d;
         coll_full_q <= coll_full_d;
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
         err_q       <= err_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

endmodule

// File: tb/tb_dct8_in_framer.sv
// tb/tb_dct8_in_framer.sv - randomized bench for dct8_in_framer against a frame-queue model
// The model keeps emitted frames in a queue (at most two in flight) and partial samples in another.
module tb_dct8_in_framer;
   localparam int W = 18;
   localparam int N = 8;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           s_valid = 1'b0;
   logic           s_last = 1'b0;
   logic           m_ready = 1'b0;
   logic [W-1:0]   s_data = '0;
   logic           s_ready, m_valid, err_frame;
   logic [N*W-1:0] m_data;
   logic [15:0]    frame_cnt;

   always #5 clk = ~clk;

   dct8_in_framer #(.W(W), .N(N), .CHECK_LAST(1'b1)) dut (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .err_frame(err_frame), .frame_cnt(frame_cnt)
   );

   int total = 0;
   int bad = 0;
   logic [N*W-1:0] out_q[$];
   logic [W-1:0]   part[$];
   logic [N*W-1:0] last_data = '0;
   logic           exp_err = 1'b0;
   logic [15:0]    exp_cnt = 16'd0;
   bit             acc = 1'b0;

   task automatic check_eq(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Applies one rising edge to the model using the inputs the bench is driving.
   task automatic model_edge();
      bit sf, mf;
      logic [N*W-1:0] f;
      sf = s_valid && (out_q.size() < 2);
      mf = (out_q.size() > 0) && m_ready;
      acc = 1'b0;
      if (reset) begin
         out_q.delete();
         part.delete();
         last_data = '0;
         exp_err = 1'b0;
         exp_cnt = 16'd0;
         return;
      end
      exp_err = 1'b0;
      acc = sf;
      if (mf) begin
         last_data = out_q.pop_front();
         exp_cnt = exp_cnt + 16'd1;
      end
      if (sf) begin
         part.push_back(s_data);
         if (part.size() == N) begin
            f = '0;
            for (int k = 0; k < N; k++) f[k*W +: W] = part[k];
            out_q.push_back(f);
            part.delete();
            if (!s_last) exp_err = 1'b1;
         end else if (s_last) begin
            part.delete();
            exp_err = 1'b1;
         end
      end
   endtask

   task automatic step();
      check_eq("m_valid", m_valid, (out_q.size() > 0));
      check_eq("s_ready", s_ready, (out_q.size() < 2));
      check_eq("m_data", m_data, (out_q.size() > 0) ? out_q[0] : last_data);
      check_eq("err_frame", err_frame, exp_err);
      check_eq("frame_cnt", frame_cnt, exp_cnt);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic send(input int v, input logic last);
      int n;
      logic [31:0] vv;
      vv = v;
      s_valid = 1'b1;
      s_data = vv[W-1:0];
      s_last = last;
      n = 0;
      do begin
         step();
         n++;
      end while (!acc && n < 40);
      if (!acc) check_eq("send_timeout", 0, 1);
   endtask

   task automatic do_reset();
      s_valid = 1'b0;
      s_last = 1'b0;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      s_last = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   int neg_vals[8] = '{-131072, 131071, -1, 1, -2, 2, 0, -100};
   logic [15:0] target;
   int guard;

   initial begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      do_reset();
      check_eq("rst_m_valid", m_valid, 0);
      check_eq("rst_s_ready", s_ready, 1);
      check_eq("rst_m_data", m_data, 0);
      check_eq("rst_cnt", frame_cnt, 0);

      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) send(i, i == 7);
      idle(3);
      check_eq("t1_cnt", frame_cnt, 1);

      for (int i = 0; i < 8; i++) send(neg_vals[i], i == 7);
      idle(3);

      do_reset();
      m_ready = 1'b0;
      for (int i = 0; i < 16; i++) send(100 + i, i % 8 == 7);
      idle(3);
      check_eq("t3_s_ready_low", s_ready, 0);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      idle(2);
      check_eq("t3_cnt", frame_cnt, 1);
      m_ready = 1'b1;
      idle(3);

      do_reset();
      send(0, 1'b0);
      send(1, 1'b0);
      send(2, 1'b1);
      for (int i = 0; i < 8; i++) send(10 + i, i == 7);
      idle(3);
      check_eq("t4_cnt", frame_cnt, 1);

      do_reset();
      target = exp_cnt + 16'd100;
      guard = 0;
      while (exp_cnt != target && guard < 5000) begin
         s_valid = ($urandom_range(0, 3) != 0);
         s_data = W'($urandom);
         s_last = (part.size() == N-1) ^ ($urandom_range(0, 19) == 0);
         step();
         guard++;
      end
      check_eq("t5_frames", exp_cnt, target);
      for (int i = 0; i < 600; i++) begin
         s_valid = ($urandom_range(0, 3) != 0);
         s_data = W'($urandom);
         s_last = (part.size() == N-1) ^ ($urandom_range(0, 19) == 0);
         m_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      m_ready = 1'b1;
      idle(4);

      force dut.frame_cnt_q = 16'hFFFF;
      #1;
      release dut.frame_cnt_q;
      exp_cnt = 16'hFFFF;
      for (int i = 0; i < 8; i++) send(200 + i, i == 7);
      idle(3);
      check_eq("wrap_cnt", frame_cnt, 0);

      m_ready = 1'b0;
      for (int i = 0; i < 13; i++) send(300 + i, i == 7);
      reset = 1'b1;
      s_valid = 1'b0;
      step();
      reset = 1'b0;
      check_eq("t6_m_valid", m_valid, 0);
      check_eq("t6_m_data", m_data, 0);
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) send(400 + i, i == 7);
      idle(3);
      check_eq("t6_cnt", frame_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
